// File: rtl/rst_sequencer.sv
// Reset sequencer: asynchronous assert, synchronised and stretched release,
// software-requested reset pulse, and a sticky record of the last reset cause.
module rst_sequencer #(
   parameter int SYNC_STAGES     = 2,
   parameter int STRETCH_CYCLES  = 16,
   parameter int SW_PULSE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       sw_rst_req,
   output logic       rstn_out,
   output logic       busy,
   output logic [1:0] state_o,
   output logic       sw_cause
);

   localparam int MAX_CYCLES = (STRETCH_CYCLES > SW_PULSE_CYCLES) ? STRETCH_CYCLES : SW_PULSE_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(SW_PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      STRETCH = 2'd1,
      RUN     = 2'd2,
      SW_RST  = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_out;
   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nxt;
   logic                   rstn_out_nxt;
   logic                   sw_cause_nxt;

   // Release edge of the raw pin is synchronised; assertion bypasses it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_out = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= HOLD;
         cnt      <= '0;
         rstn_out <= 1'b0;
         sw_cause <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         rstn_out <= rstn_out_nxt;
         sw_cause <= sw_cause_nxt;
      end
   end

   // rstn_out is computed one edge ahead so the output itself stays a bare flop.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      rstn_out_nxt = 1'b0;
      sw_cause_nxt = sw_cause;
      case (state)
         HOLD: begin
            cnt_nxt = '0;
            if (sync_out) begin
               state_nxt = STRETCH;
            end
         end
         STRETCH: begin
            if (cnt == STRETCH_LAST) begin
               state_nxt    = RUN;
               cnt_nxt      = '0;
               rstn_out_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RUN: begin
            cnt_nxt      = '0;
            rstn_out_nxt = 1'b1;
            if (sw_rst_req) begin
               state_nxt    = SW_RST;
               rstn_out_nxt = 1'b0;
               sw_cause_nxt = 1'b1;
            end
         end
         SW_RST: begin
            if (cnt == PULSE_LAST) begin
               state_nxt = STRETCH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign busy    = (state != RUN);
   assign state_o = state;

endmodule
